// File: rtl/async_fifo_package.sv
// Shared types and pointer helpers for both clock domains of the async FIFO.
// Pointers carry one extra MSB so that full and empty can be told apart.
package async_fifo_package;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

  typedef logic [PTR_WIDTH-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into clk.
// Only one bit changes per source update, so a plain flop chain is safe.
module ptr_sync #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the async FIFO: pointer sync, empty flag,
// memory read port and a first-word-fall-through output stream.
module fifo_read_ctrl
  import async_fifo_package::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic [PTR_WIDTH-1:0]  wptr_gray,
  output logic [PTR_WIDTH-1:0]  rptr_gray,
  output logic                  mem_r_en,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  input  logic [DATA_WIDTH-1:0] mem_r_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [PTR_WIDTH-1:0]  rd_level
);

  ptr_t wq_gray;
  ptr_t wq_bin;
  ptr_t rbin;
  ptr_t rbin_next;
  logic issue;

  ptr_sync #(
    .WIDTH       (PTR_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (r_clk),
    .rst_n (r_rst_n),
    .d     (wptr_gray),
    .q     (wq_gray)
  );

  // Handshake: a word transfers on a cycle where rd_valid && rd_ready.
  // rd_valid never drops and rd_data never changes while rd_ready is low.
  // A fetch is issued whenever the output slot is free or being freed now.
  assign issue      = !empty && (!rd_valid || rd_ready);
  assign rbin_next  = rbin + ptr_t'(issue);
  assign mem_r_en   = issue;
  assign mem_r_addr = rbin[ADDR_WIDTH-1:0];
  assign rd_data    = mem_r_data;
  assign wq_bin     = gray2bin(wq_gray);
  assign rd_level   = wq_bin - rbin;

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      empty     <= 1'b1;
      rd_valid  <= 1'b0;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= bin2gray(rbin_next);
      empty     <= (bin2gray(rbin_next) == wq_gray);
      if (issue) begin
        rd_valid <= 1'b1;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a word-queue model of the FIFO.
module tb_fifo_read_ctrl;
  import async_fifo_package::*;

  logic                  r_clk;
  logic                  r_rst_n;
  logic [PTR_WIDTH-1:0]  wptr_gray;
  logic [PTR_WIDTH-1:0]  rptr_gray;
  logic                  mem_r_en;
  logic [ADDR_WIDTH-1:0] mem_r_addr;
  logic [DATA_WIDTH-1:0] mem_r_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic [PTR_WIDTH-1:0]  rd_level;

  fifo_read_ctrl #(.SYNC_STAGES(2)) dut (
    .r_clk      (r_clk),
    .r_rst_n    (r_rst_n),
    .wptr_gray  (wptr_gray),
    .rptr_gray  (rptr_gray),
    .mem_r_en   (mem_r_en),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .empty      (empty),
    .rd_level   (rd_level)
  );

  // clock / reset
  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  // memory with registered read port
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  initial mem_r_data = '0;
  always @(posedge r_clk) begin
    if (mem_r_en) mem_r_data <= mem[mem_r_addr];
  end

  // scoreboard state
  logic [DATA_WIDTH-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int wcnt = 0;
  int fetched = 0;
  int delivered = 0;
  logic prev_hold = 1'b0;
  logic [DATA_WIDTH-1:0] prev_data = '0;
  ptr_t prev_rptr = '0;

  function automatic logic [DATA_WIDTH-1:0] word_val(input int k);
    return DATA_WIDTH'(k * 37 + 5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  task automatic write_word();
    mem[wcnt % DEPTH] = word_val(wcnt);
    exp_q.push_back(word_val(wcnt));
    wcnt++;
    wptr_gray = bin2gray(ptr_t'(wcnt));
  endtask

  task automatic do_reset();
    rd_ready  = 1'b0;
    r_rst_n   = 1'b0;
    wcnt      = 0;
    wptr_gray = '0;
    exp_q.delete();
    step();
    step();
    r_rst_n = 1'b1;
  endtask

  // per-cycle compare against the queue model
  always @(negedge r_clk) begin
    if (!r_rst_n) begin
      fetched   = 0;
      delivered = 0;
      prev_hold = 1'b0;
      prev_rptr = '0;
    end else begin
      chk("rptr_gray", 32'(rptr_gray), 32'(bin2gray(ptr_t'(fetched))));
      chk("rptr_one_bit", 32'($countones(rptr_gray ^ prev_rptr) <= 1), 32'd1);
      prev_rptr = rptr_gray;
      if (prev_hold) begin
        chk("hold_valid", 32'(rd_valid), 32'd1);
        chk("hold_data", 32'(rd_data), 32'(prev_data));
      end
      if (!empty) chk("empty_false_clear", 32'(fetched < wcnt), 32'd1);
      chk("rd_level_bound", 32'(int'(rd_level) <= wcnt - fetched), 32'd1);
      if (mem_r_en) begin
        chk("mem_r_addr", 32'(mem_r_addr), 32'(fetched % DEPTH));
        chk("read_unwritten", 32'(fetched < wcnt), 32'd1);
        fetched++;
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", 32'(rd_data), 32'hFFFF_FFFF);
        end else begin
          chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        delivered++;
      end
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
    end
  end

  initial begin
    int cyc;
    int reads;
    r_rst_n   = 1'b1;
    rd_ready  = 1'b0;
    wptr_gray = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // 1: asynchronous reset clears outputs before any clock edge
    #2 r_rst_n = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_mem_r_en", 32'(mem_r_en), 32'd0);
    chk("rst_rptr", 32'(rptr_gray), 32'd0);
    chk("rst_rd_level", 32'(rd_level), 32'd0);
    do_reset();

    // 2: single word, first-word latency
    rd_ready = 1'b1;
    write_word();
    step(); chk("t2_empty_e1", 32'(empty), 32'd1);
    step(); chk("t2_empty_e2", 32'(empty), 32'd1);
    step();
    chk("t2_empty_e3", 32'(empty), 32'd0);
    chk("t2_mem_r_en", 32'(mem_r_en), 32'd1);
    chk("t2_addr", 32'(mem_r_addr), 32'd0);
    step();
    chk("t2_valid", 32'(rd_valid), 32'd1);
    chk("t2_data", 32'(rd_data), 32'h05);
    chk("t2_empty_after", 32'(empty), 32'd1);
    chk("t2_rptr", 32'(rptr_gray), 32'b00001);
    step();
    chk("t2_valid_drop", 32'(rd_valid), 32'd0);

    // 3: backpressure holds the first word, then a burst drains the rest
    do_reset();
    for (int k = 0; k < 4; k++) write_word();
    chk("t3_wptr", 32'(wptr_gray), 32'b00110);
    step(); step(); step();
    chk("t3_first_read", 32'(mem_r_en), 32'd1);
    chk("t3_first_addr", 32'(mem_r_addr), 32'd0);
    reads = 1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (mem_r_en) reads++;
      chk("t3_hold_valid", 32'(rd_valid), 32'd1);
      chk("t3_hold_data", 32'(rd_data), 32'h05);
    end
    chk("t3_one_read", 32'(reads), 32'd1);
    rd_ready = 1'b1;
    chk("t3_next_addr", 32'(mem_r_addr), 32'd1);
    step(); chk("t3_w1", 32'(rd_data), 32'h2A); chk("t3_v1", 32'(rd_valid), 32'd1);
    step(); chk("t3_w2", 32'(rd_data), 32'h4F); chk("t3_v2", 32'(rd_valid), 32'd1);
    step(); chk("t3_w3", 32'(rd_data), 32'h74); chk("t3_v3", 32'(rd_valid), 32'd1);
    chk("t3_rptr_end", 32'(rptr_gray), 32'b00110);
    step(); chk("t3_valid_drop", 32'(rd_valid), 32'd0);

    // 4: 40-word stream through a 16-deep memory, two pointer wraps
    do_reset();
    rd_ready = 1'b1;
    cyc = 0;
    while (delivered < 40 && cyc < 600) begin
      if (wcnt < 40 && (wcnt - delivered) < DEPTH) write_word();
      step();
      cyc++;
    end
    chk("t4_delivered", 32'(delivered), 32'd40);
    chk("t4_rptr_end", 32'(rptr_gray), 32'b01100);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: rd_ready toggling every cycle
    do_reset();
    for (int k = 0; k < 12; k++) write_word();
    cyc = 0;
    while (delivered < 12 && cyc < 200) begin
      rd_ready = ~rd_ready;
      step();
      cyc++;
    end
    chk("t5_delivered", 32'(delivered), 32'd12);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: reset mid-stream, then restart from address 0
    do_reset();
    for (int k = 0; k < 12; k++) write_word();
    rd_ready = 1'b1;
    cyc = 0;
    while (fetched != 7 && cyc < 50) begin
      step();
      cyc++;
    end
    chk("t6_reach_rbin7", 32'(fetched), 32'd7);
    rd_ready = 1'b0;
    chk("t6_valid_before", 32'(rd_valid), 32'd1);
    #1 r_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(rd_valid), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_rptr", 32'(rptr_gray), 32'd0);
    chk("t6_rst_mem_r_en", 32'(mem_r_en), 32'd0);
    step();
    r_rst_n = 1'b1;
    exp_q.delete();
    wcnt = 10;
    for (int k = 0; k < 10; k++) exp_q.push_back(word_val(k));
    wptr_gray = bin2gray(ptr_t'(10));
    step();
    step();
    chk("t6_rd_level", 32'(rd_level), 32'd10);
    chk("t6_empty_synced", 32'(empty), 32'd1);
    step();
    chk("t6_restart_read", 32'(mem_r_en), 32'd1);
    chk("t6_restart_addr", 32'(mem_r_addr), 32'd0);
    rd_ready = 1'b1;
    cyc = 0;
    while (delivered < 10 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("t6_delivered", 32'(delivered), 32'd10);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Read-domain controller for the async FIFO, the consumer-side counterpart to the write path into dualport_mem. It synchronises the write pointer into r_clk and keeps the read pointer in binary and Gray. It generates the registered empty flag and drives the memory read port. It presents data to the consumer as a first-word-fall-through valid/ready stream.

Parameters:
SYNC_STAGES, 2, flops in the write-pointer synchroniser; legal values 2..4
(DATA_WIDTH, ADDR_WIDTH and DEPTH come from async_fifo_package; DEPTH = 2**ADDR_WIDTH)

Ports:
r_clk  in  1  read-domain clock
r_rst_n  in  1  asynchronous active-low reset
wptr_gray  in  ADDR_WIDTH+1  write pointer (Gray), asynchronous to r_clk
rptr_gray  out  ADDR_WIDTH+1  registered read pointer (Gray), to write domain
mem_r_en  out  1  memory read enable
mem_r_addr  out  ADDR_WIDTH  memory read address
mem_r_data  in  DATA_WIDTH  memory registered read data; memory holds it while mem_r_en=0
rd_valid  out  1  rd_data holds a valid word
rd_ready  in  1  consumer accepts the word
rd_data  out  DATA_WIDTH  output word
empty  out  1  registered empty flag: no unread word in memory
rd_level  out  ADDR_WIDTH+1  words in memory not yet fetched; excludes the word held at the output

Behaviour:
- Reset (async assert, sync release): synchroniser flops = 0, rbin = 0, rptr_gray = 0, empty = 1, rd_valid = 0, mem_r_en = 0, rd_level = 0. A word held at the output when reset asserts is discarded.
- Sync: wptr_gray passes through SYNC_STAGES flops to give wq_gray. wq_bin = gray2bin(wq_gray).
- Issue = !empty && (!rd_valid || rd_ready). This is combinational.
  - mem_r_en = issue.
  - mem_r_addr = rbin[ADDR_WIDTH-1:0].
- rbin_next = rbin + issue, computed modulo 2**(ADDR_WIDTH+1).
  - rptr_gray <= bin2gray(rbin_next).
  - empty <= (bin2gray(rbin_next) == wq_gray).
- rd_valid:
  - Set to 1 on issue.
  - Otherwise cleared on rd_ready.
  - Otherwise held.
- rd_data = mem_r_data. This is a pass-through; no extra register.
- Latency: empty falls in cycle t → mem_r_en in cycle t → rd_valid=1 and data valid in cycle t+1.
- Throughput: one word per cycle while rd_ready=1 and the memory is non-empty.
- Backpressure: while rd_valid=1 and rd_ready=0, issue=0, so rd_data and rd_valid are stable.
- Simultaneous accept and issue: rd_valid stays 1 and rd_data updates to the next word.
- rd_ready while rd_valid=0: ignored.
- Empty while the output holds a word: the word is retained until accepted; then rd_valid falls.
- Wrap: the address field wraps DEPTH-1 → 0, and the MSB of rbin toggles. rptr_gray changes exactly one bit per increment.
- Pessimism: empty may stay asserted up to SYNC_STAGES+1 cycles after a write; it never deasserts falsely.
- rd_level = wq_bin - rbin, modulo 2**(ADDR_WIDTH+1), computed from registers.
- No overflow/underflow handling is needed. Reads can never pass the synchronised write pointer by construction.

Decomposition:
- async_fifo_package gains:
  - PTR_WIDTH = ADDR_WIDTH+1;
  - typedef ptr_t (logic [PTR_WIDTH-1:0]);
  - functions bin2gray and gray2bin.
- The write-side controller will reuse these.
- One sub-module: ptr_sync, a parameterised width × SYNC_STAGES flop chain with async active-low reset, also to be reused by the write side.

Test Plan:
All scenarios use ADDR_WIDTH=4, DEPTH=16, SYNC_STAGES=2.
1. Reset with wptr_gray=0 → empty=1, rd_valid=0, mem_r_en=0, rptr_gray=5'b00000, rd_level=0. Outputs clear on r_rst_n fall without a clock edge.
2. wptr_gray 0→1 with rd_ready=1 → empty=0 after the 3rd r_clk edge. mem_r_en=1 with mem_r_addr=0 in that cycle. Next cycle rd_valid=1 with rd_data=mem[0], empty=1, rptr_gray=5'b00001.
3. Four words written (wptr_gray=bin2gray(4)=5'b00110), rd_ready=0 → exactly one memory read; rd_valid held with rd_data=mem[0] for 10 cycles. Then rd_ready=1 → mem[1..3] on consecutive cycles. rptr_gray ends at 5'b00110 and rd_valid drops after mem[3] is accepted.
4. Stream 40 words with a write model that never overfills, rd_ready=1 → addresses 0..15,0..15,0..7 in order with no gaps or duplicates. rptr_gray changes one bit per increment, and the pointer MSB toggles at words 16 and 32.
5. rd_ready toggles 1/0 every cycle over 12 words → every word is delivered exactly once, in order, and rd_data is stable whenever rd_valid=1 and rd_ready=0.
6. r_rst_n pulsed low mid-stream with rd_valid=1 and rbin=7 → immediate rd_valid=0, empty=1, rptr_gray=0. After release and a re-synchronised wptr_gray of bin2gray(10), rd_level=10 and reads restart at address 0.
